// File: rtl/iob_cache_evict_pkg.sv
// Shared definitions for the cache victim eviction engine: FSM state
// encodings and the width helpers for the back-end byte address.
package iob_cache_evict_pkg;

    // Eviction FSM states (3-bit encoding)
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_CAPT = 3'd2,
        ST_SEND = 3'd3,
        ST_DONE = 3'd4
    } evict_state_t;

    // Default word width, used for the package-level byte-offset width
    localparam int DEFAULT_DATA_W = 32;

    // Byte-offset bits inside one word for the default word width
    localparam int BYTE_OFFSET_W = $clog2(DEFAULT_DATA_W / 8);

    // Byte-offset bits inside one word for an arbitrary word width
    function automatic int byte_offset_width(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    // Back-end byte address = {tag, line, word, byte}
    function automatic int be_addr_width(input int tag_w, input int nlines_w,
                                         input int word_offset_w, input int data_w);
        return tag_w + nlines_w + word_offset_w + byte_offset_width(data_w);
    endfunction

endpackage

// File: rtl/iob_cache_victim_evict.sv
// Victim eviction engine: on a write-back miss, reads a valid+dirty victim
// line word by word from data memory, streams each word to the back-end
// write channel, then pulses done and requests a dirty-bit clear.
module iob_cache_victim_evict
    import iob_cache_evict_pkg::*;
#(
    parameter int N_WAYS        = 4,
    parameter int NWAYS_W       = $clog2(N_WAYS),
    parameter int NLINES_W      = 7,
    parameter int WORD_OFFSET_W = 3,
    parameter int DATA_W        = 32,
    parameter int TAG_W         = 20,
    parameter int BE_ADDR_W     = be_addr_width(TAG_W, NLINES_W, WORD_OFFSET_W, DATA_W)
) (
    input  logic                              clk_i,
    input  logic                              arst_n_i,
    input  logic                              cke_i,
    input  logic                              evict_req_i,
    input  logic [NWAYS_W-1:0]                way_select_bin_i,
    input  logic [NLINES_W-1:0]               line_addr_i,
    input  logic [N_WAYS-1:0]                 valid_i,
    input  logic [N_WAYS-1:0]                 dirty_i,
    input  logic [N_WAYS*TAG_W-1:0]           tag_i,
    output logic                              evict_busy_o,
    output logic                              evict_done_o,
    output logic                              dirty_clr_o,
    output logic [NWAYS_W-1:0]                dirty_clr_way_o,
    output logic                              dmem_en_o,
    output logic [NWAYS_W-1:0]                dmem_way_o,
    output logic [NLINES_W+WORD_OFFSET_W-1:0] dmem_addr_o,
    input  logic [DATA_W-1:0]                 dmem_rdata_i,
    output logic                              be_valid_o,
    output logic [BE_ADDR_W-1:0]              be_addr_o,
    output logic [DATA_W-1:0]                 be_wdata_o,
    output logic [DATA_W/8-1:0]               be_wstrb_o,
    input  logic                              be_ready_i
);

    localparam int BYTE_W = byte_offset_width(DATA_W);

    evict_state_t               state_reg;
    evict_state_t               state_next;
    logic [NWAYS_W-1:0]         way_reg;
    logic [NLINES_W-1:0]        line_reg;
    logic [TAG_W-1:0]           tag_reg;
    logic                       need_reg;
    logic [WORD_OFFSET_W-1:0]   cnt_reg;
    logic [DATA_W-1:0]          wdata_reg;

    logic [TAG_W-1:0]           tag_way [N_WAYS];
    logic                       req_need;
    logic                       last_word;
    logic [BE_ADDR_W-1:0]       send_addr;

    // Split the flat tag bus into one tag per way
    for (genvar gi = 0; gi < N_WAYS; gi++) begin : g_tag_way
        assign tag_way[gi] = tag_i[gi*TAG_W +: TAG_W];
    end

    // Only a line that is both valid and dirty has to be written back
    assign req_need  = valid_i[way_select_bin_i] & dirty_i[way_select_bin_i];
    assign last_word = &cnt_reg;
    assign send_addr = BE_ADDR_W'({tag_reg, line_reg, cnt_reg}) << BYTE_W;

    // State register; cke low freezes the whole engine
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_reg <= ST_IDLE;
        end else if (cke_i) begin
            state_reg <= state_next;
        end
    end

    // Victim holding registers, word counter and captured read data
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            way_reg   <= '0;
            line_reg  <= '0;
            tag_reg   <= '0;
            need_reg  <= 1'b0;
            cnt_reg   <= '0;
            wdata_reg <= '0;
        end else if (cke_i) begin
            if (state_reg == ST_IDLE && evict_req_i) begin
                way_reg  <= way_select_bin_i;
                line_reg <= line_addr_i;
                tag_reg  <= tag_way[way_select_bin_i];
                need_reg <= req_need;
                cnt_reg  <= '0;
            end
            if (state_reg == ST_CAPT) begin
                wdata_reg <= dmem_rdata_i;
            end
            // The counter stops on the last word so it never wraps mid-eviction
            if (state_reg == ST_SEND && be_ready_i && !last_word) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    // Next-state decode and all outputs, decoded from the current state
    always_comb begin
        state_next      = state_reg;
        evict_busy_o    = (state_reg != ST_IDLE);
        evict_done_o    = 1'b0;
        dirty_clr_o     = 1'b0;
        dirty_clr_way_o = '0;
        dmem_en_o       = 1'b0;
        dmem_way_o      = '0;
        dmem_addr_o     = '0;
        be_valid_o      = 1'b0;
        be_addr_o       = '0;
        be_wdata_o      = '0;
        be_wstrb_o      = '0;
        unique case (state_reg)
            ST_IDLE: begin
                if (evict_req_i) begin
                    state_next = req_need ? ST_READ : ST_DONE;
                end
            end
            ST_READ: begin
                dmem_en_o   = 1'b1;
                dmem_way_o  = way_reg;
                dmem_addr_o = {line_reg, cnt_reg};
                state_next  = ST_CAPT;
            end
            ST_CAPT: begin
                state_next = ST_SEND;
            end
            ST_SEND: begin
                be_valid_o = 1'b1;
                be_addr_o  = send_addr;
                be_wdata_o = wdata_reg;
                be_wstrb_o = '1;
                if (be_ready_i) begin
                    state_next = last_word ? ST_DONE : ST_READ;
                end
            end
            ST_DONE: begin
                evict_done_o = 1'b1;
                if (need_reg) begin
                    dirty_clr_o     = 1'b1;
                    dirty_clr_way_o = way_reg;
                end
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_iob_cache_victim_evict.sv
// Scoreboard bench for the victim eviction engine (4 words per line).
// Stimulus pushes the expected write-backs and done pulse; a negedge monitor
// pops and compares whatever the DUT presents.
module tb_iob_cache_victim_evict;

    logic         clk = 1'b0;
    logic         arst_n = 1'b0;
    logic         cke = 1'b1;
    logic         req = 1'b0;
    logic [1:0]   way_sel = '0;
    logic [6:0]   line = '0;
    logic [3:0]   valid = '0;
    logic [3:0]   dirty = '0;
    logic [79:0]  tags = '0;
    logic         busy, done, dclr;
    logic [1:0]   dclr_way;
    logic         dmem_en;
    logic [1:0]   dmem_way;
    logic [8:0]   dmem_addr;
    logic [31:0]  dmem_rdata = '0;
    logic         be_valid;
    logic [30:0]  be_addr;
    logic [31:0]  be_wdata;
    logic [3:0]   be_wstrb;
    logic         be_ready = 1'b1;

    int total = 0;
    int passed = 0;
    int hold_cnt = 0;
    bit rand_ready = 0;

    typedef struct {
        logic [1:0]  way;
        logic [8:0]  maddr;
        logic [30:0] addr;
        logic [31:0] data;
    } wr_t;
    typedef struct {
        logic       clr;
        logic [1:0] way;
    } done_t;

    wr_t   exp_wr[$];
    done_t exp_done[$];

    iob_cache_victim_evict #(
        .N_WAYS(4), .NLINES_W(7), .WORD_OFFSET_W(2), .DATA_W(32), .TAG_W(20)
    ) dut (
        .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke),
        .evict_req_i(req), .way_select_bin_i(way_sel), .line_addr_i(line),
        .valid_i(valid), .dirty_i(dirty), .tag_i(tags),
        .evict_busy_o(busy), .evict_done_o(done),
        .dirty_clr_o(dclr), .dirty_clr_way_o(dclr_way),
        .dmem_en_o(dmem_en), .dmem_way_o(dmem_way), .dmem_addr_o(dmem_addr),
        .dmem_rdata_i(dmem_rdata),
        .be_valid_o(be_valid), .be_addr_o(be_addr), .be_wdata_o(be_wdata),
        .be_wstrb_o(be_wstrb), .be_ready_i(be_ready)
    );

    always #5 clk = ~clk;

    // Data memory contents: a fixed, distinct word per (way, address)
    function automatic logic [31:0] mem_word(input logic [1:0] w, input logic [8:0] a);
        return 32'h1234_5678 ^ ({23'd0, a} * 32'h0101_0101) ^ ({30'd0, w} << 28);
    endfunction

    // Synchronous-read memory model: data valid one cycle after the enable
    always @(posedge clk) begin
        if (dmem_en) dmem_rdata <= mem_word(dmem_way, dmem_addr);
    end

    // Back-end ready: forced low while hold_cnt runs, else always/random high
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (hold_cnt > 0) begin
                be_ready = 1'b0;
                hold_cnt--;
            end else begin
                be_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    task automatic chk(input string name, input bit ok, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: a valid+dirty victim yields one write per word, in order,
    // at {tag, line, word, 00} carrying the memory word; then one done.
    task automatic push_expect(input logic [1:0] w, input logic [6:0] l, input logic [3:0] v,
                               input logic [3:0] d, input logic [79:0] t);
        wr_t   e;
        done_t dn;
        logic  need;
        need = v[w] & d[w];
        if (need) begin
            for (int k = 0; k < 4; k++) begin
                e.way   = w;
                e.maddr = l * 9'd4 + 9'(k);
                e.addr  = 31'(t[w*20 +: 20]) * 31'd2048 + 31'(l) * 31'd16 + 31'(k) * 31'd4;
                e.data  = mem_word(w, e.maddr);
                exp_wr.push_back(e);
            end
        end
        dn.clr = need;
        dn.way = need ? w : 2'd0;
        exp_done.push_back(dn);
    endtask

    task automatic issue(input logic [1:0] w, input logic [6:0] l, input logic [3:0] v,
                         input logic [3:0] d, input logic [79:0] t);
        @(posedge clk);
        #1;
        req = 1'b1; way_sel = w; line = l; valid = v; dirty = d; tags = t;
        push_expect(w, l, v, d, t);
        @(posedge clk);
        #1;
        req = 1'b0;
    endtask

    // Issue one eviction and measure cycles from request to done
    task automatic run_evict(input string name, input logic [1:0] w, input logic [6:0] l,
                             input logic [3:0] v, input logic [3:0] d, input logic [79:0] t,
                             input int exp_lat);
        int lat;
        bit got;
        issue(w, l, v, d, t);
        lat = 1;
        got = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done && cke) begin
                got = 1;
                break;
            end
            lat++;
        end
        if (!got) chk({name, "_timeout"}, 0, 96'(lat), 96'(exp_lat));
        else if (exp_lat >= 0) chk({name, "_latency"}, lat == exp_lat, 96'(lat), 96'(exp_lat));
        $display("evict %s way=%0d line=%0h need=%0d latency=%0d", name, w, l, v[w] & d[w], lat);
    endtask

    task automatic wait_accept(input string name);
        bit got = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (be_valid && be_ready) begin
                got = 1;
                break;
            end
        end
        if (!got) chk({name, "_accept_timeout"}, 0, 0, 1);
    endtask

    // Monitor: compares every read, accepted write and done pulse
    int       reads = 0;
    int       accs = 0;
    bit       stalled = 0;
    logic [30:0] st_addr;
    logic [31:0] st_data;
    always @(negedge clk) begin
        if (!arst_n) begin
            reads = 0;
            accs = 0;
            stalled = 0;
        end else begin
            if (stalled)
                chk("stall_hold", be_valid && be_addr == st_addr && be_wdata == st_data,
                    {be_valid, be_addr, be_wdata}, {1'b1, st_addr, st_data});
            stalled = 0;
            if (cke) begin
                if (dmem_en) begin
                    if (exp_wr.size() == 0) chk("read_unexpected", 0, {dmem_way, dmem_addr}, 0);
                    else chk("read_addr", reads == accs && dmem_way == exp_wr[0].way && dmem_addr == exp_wr[0].maddr,
                             {64'(reads - accs), dmem_way, dmem_addr}, {64'd0, exp_wr[0].way, exp_wr[0].maddr});
                    reads++;
                end
                if (be_valid && be_ready) begin
                    if (exp_wr.size() == 0) begin
                        chk("write_unexpected", 0, {be_addr, be_wdata}, 0);
                    end else begin
                        wr_t e;
                        e = exp_wr.pop_front();
                        $display("write addr=%h data=%h strb=%h", be_addr, be_wdata, be_wstrb);
                        chk("write_addr", be_addr == e.addr, 96'(be_addr), 96'(e.addr));
                        chk("write_data", be_wdata == e.data, 96'(be_wdata), 96'(e.data));
                        chk("write_strb", be_wstrb == 4'hF, 96'(be_wstrb), 96'hF);
                    end
                    accs++;
                end else if (be_valid) begin
                    stalled = 1;
                    st_addr = be_addr;
                    st_data = be_wdata;
                end
                if (done) begin
                    if (exp_done.size() == 0) begin
                        chk("done_unexpected", 0, 1, 0);
                    end else begin
                        done_t dn;
                        dn = exp_done.pop_front();
                        chk("done_clear", dclr == dn.clr && dclr_way == dn.way && exp_wr.size() == 0,
                            {64'(exp_wr.size()), dclr, dclr_way}, {64'd0, dn.clr, dn.way});
                    end
                    reads = 0;
                    accs = 0;
                end else if (dclr) begin
                    chk("clear_without_done", 0, 1, 0);
                end
            end
        end
    end

    function automatic logic [84:0] all_outs();
        return {busy, done, dclr, dclr_way, dmem_en, dmem_way, dmem_addr,
                be_valid, be_addr, be_wdata, be_wstrb};
    endfunction

    initial begin
        logic [79:0] t;
        logic [3:0]  v, d;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", all_outs() == '0, 96'(all_outs()), 0);
        arst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", all_outs() == '0, 96'(all_outs()), 0);

        // Clean victim
        t = {20'h11111, 20'h22222, 20'h33333, 20'h44444};
        run_evict("clean", 2'd2, 7'd5, 4'b0100, 4'b0000, t, 1);

        // Dirty victim, way 1 tag 0xABCDE
        t = {20'h13579, 20'h2468A, 20'hABCDE, 20'h0F0F0};
        run_evict("dirty", 2'd1, 7'h12, 4'b0010, 4'b0010, t, 13);

        // Backpressure: ready held low for the first 5 cycles of word 1
        fork
            run_evict("backpressure", 2'd3, 7'h40, 4'b1111, 4'b1000, t, 18);
            begin
                wait_accept("backpressure");
                hold_cnt = 7;
            end
        join

        // Second request during SEND with another way must be ignored
        fork
            run_evict("ignore_req", 2'd0, 7'h7F, 4'b0001, 4'b0001, t, 13);
            begin
                bit got = 0;
                for (int i = 0; i < 100; i++) begin
                    @(negedge clk);
                    if (be_valid) begin
                        got = 1;
                        break;
                    end
                end
                if (!got) chk("ignore_valid_timeout", 0, 0, 1);
                req = 1'b1; way_sel = 2'd3; line = 7'h01; valid = 4'hF; dirty = 4'hF; tags = ~t;
                @(posedge clk);
                #1;
                req = 1'b0;
            end
        join

        // Clock enable low for 3 cycles while capturing word 0
        fork
            run_evict("cke_stall", 2'd2, 7'h33, 4'b0100, 4'b0100, t, 16);
            begin
                bit got = 0;
                for (int i = 0; i < 100; i++) begin
                    @(negedge clk);
                    if (dmem_en) begin
                        got = 1;
                        break;
                    end
                end
                if (!got) chk("cke_read_timeout", 0, 0, 1);
                @(posedge clk);
                #1;
                cke = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                cke = 1'b1;
            end
        join

        // Asynchronous reset during the second word's SEND aborts the eviction
        issue(2'd1, 7'h2A, 4'b0010, 4'b0010, t);
        wait_accept("reset_abort");
        hold_cnt = 100;
        begin
            bit got = 0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (be_valid && be_addr[3:2] == 2'd1) begin
                    got = 1;
                    break;
                end
            end
            if (!got) chk("reset_word1_timeout", 0, 0, 1);
        end
        @(posedge clk);
        #2;
        arst_n = 1'b0;
        #1;
        chk("abort_outputs", all_outs() == '0, 96'(all_outs()), 0);
        exp_wr.delete();
        exp_done.delete();
        hold_cnt = 0;
        @(posedge clk);
        #3;
        arst_n = 1'b1;
        @(negedge clk);
        chk("abort_idle", all_outs() == '0, 96'(all_outs()), 0);
        run_evict("after_abort", 2'd1, 7'h2A, 4'b0010, 4'b0010, t, 13);

        // Random victims with ready held high: latency is fully predictable
        for (int n = 0; n < 10; n++) begin
            t = {16'($urandom()), $urandom(), $urandom()};
            v = 4'($urandom());
            d = 4'($urandom());
            way_sel = 2'($urandom());
            run_evict("rand", way_sel, 7'($urandom()), v, d, t, (v[way_sel] & d[way_sel]) ? 13 : 1);
        end

        // Random victims with random back-end ready
        rand_ready = 1;
        for (int n = 0; n < 15; n++) begin
            t = {16'($urandom()), $urandom(), $urandom()};
            v = 4'($urandom()) | 4'b0001;
            d = 4'($urandom()) | 4'b0001;
            way_sel = 2'($urandom());
            run_evict("rand_bp", way_sel, 7'($urandom()), v, d, t, -1);
        end
        rand_ready = 0;

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", exp_wr.size() == 0 && exp_done.size() == 0,
            96'(exp_wr.size() + exp_done.size()), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
